// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file's single write port
// among four requesters. Each cycle at most one request wins. The winning
// write is registered and presented to the register file in the next cycle.
// Writes to R15 can be restricted to requester 0.
module regfile_write_arbiter #(
    parameter int WIDTH       = 32,
    parameter int PROTECT_R15 = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [15:0]        req_addr,
    input  logic [4*WIDTH-1:0] req_data,
    output logic [3:0]         grant,
    output logic [3:0]         err,
    output logic               wr_en,
    output logic [3:0]         wr_addr,
    output logic [WIDTH-1:0]   wr_data
);

    logic [3:0]       addr_a [4];
    logic [WIDTH-1:0] data_a [4];
    logic [3:0]       illegal;
    logic [3:0]       elig;

    logic [3:0]       grant_q, grant_d;
    logic [3:0]       err_q, err_d;
    logic             wr_en_q, wr_en_d;
    logic [3:0]       wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [1:0]       last_q, last_d;

    logic [1:0]       win;
    logic [1:0]       idx;
    logic             any_elig;

    // Unpack each requester's fields and classify its request.
    // Requester 0 is always trusted to write R15.
    // A requester granted this cycle sits out one arbitration round.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign addr_a[gi] = req_addr[4*gi +: 4];
            assign data_a[gi] = req_data[WIDTH*gi +: WIDTH];
            if (gi == 0) begin : g_trusted
                assign illegal[gi] = 1'b0;
            end else begin : g_checked
                assign illegal[gi] = (PROTECT_R15 != 0) && req[gi] &&
                                     (addr_a[gi] == 4'hF);
            end
            assign elig[gi] = req[gi] && !illegal[gi] && !grant_q[gi];
        end
    endgenerate

    assign any_elig = |elig;

    // Pick the first eligible requester after the last winner.
    // The scan wraps around and ends on the last winner itself.
    // Iterating from the farthest offset down lets the nearest one win.
    always_comb begin
        win = last_q;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = last_q + 2'(k + 1);
            if (elig[idx]) begin
                win = idx;
            end
        end
    end

    // Next-state for the registered write port. When nothing is
    // eligible, the address and data simply hold.
    always_comb begin
        err_d     = illegal;
        wr_en_d   = any_elig;
        grant_d   = 4'b0000;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        last_d    = last_q;
        if (any_elig) begin
            grant_d   = 4'b0001 << win;
            wr_addr_d = addr_a[win];
            wr_data_d = data_a[win];
            last_d    = win;
        end
    end

    // State registers. The reset value of last_q (3) gives requester 0
    // first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q   <= 4'b0000;
            err_q     <= 4'b0000;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 4'h0;
            wr_data_q <= '0;
            last_q    <= 2'd3;
        end else begin
            grant_q   <= grant_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            last_q    <= last_d;
        end
    end

    assign grant   = grant_q;
    assign err     = err_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus randomized bench for regfile_write_arbiter.
// A rule-level reference model predicts every registered output on every
// cycle.
module tb_regfile_write_arbiter;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         req;
    logic [15:0]        req_addr;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         grant;
    logic [3:0]         err;
    logic               wr_en;
    logic [3:0]         wr_addr;
    logic [WIDTH-1:0]   wr_data;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int               m_last;
    logic [3:0]       m_grant;
    logic [3:0]       m_err;
    logic             m_wr_en;
    logic [3:0]       m_wr_addr;
    logic [WIDTH-1:0] m_wr_data;

    regfile_write_arbiter #(.WIDTH(WIDTH), .PROTECT_R15(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .grant    (grant),
        .err      (err),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the specification's rules to the inputs sampled at this edge.
    task automatic model_edge();
        logic [3:0] ill;
        logic [3:0] el;
        int found;
        if (reset) begin
            m_grant = 0; m_err = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
            m_last = 3;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ill[i] = (i != 0) && req[i] && (req_addr[4*i +: 4] == 4'hF);
                el[i]  = req[i] && !ill[i] && !m_grant[i];
            end
            found = -1;
            for (int k = 1; k <= 4; k++) begin
                if (found < 0 && el[(m_last + k) % 4]) found = (m_last + k) % 4;
            end
            m_err = ill;
            if (found >= 0) begin
                m_wr_en   = 1;
                m_wr_addr = req_addr[4*found +: 4];
                m_wr_data = req_data[WIDTH*found +: WIDTH];
                m_grant   = 4'b0001 << found;
                m_last    = found;
            end else begin
                m_wr_en = 0;
                m_grant = 0;
            end
        end
    endtask

    // Advance one clock; compare all outputs against the model 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("grant",   32'(grant),   32'(m_grant));
        check("err",     32'(err),     32'(m_err));
        check("wr_en",   32'(wr_en),   32'(m_wr_en));
        check("grant_onehot", 32'($onehot0(grant)), 32'd1);
        if (m_wr_en) begin
            check("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
            check("wr_data", wr_data, m_wr_data);
        end
        $display("t=%0t rst=%b req=%b grant=%b err=%b wr_en=%b addr=%h data=%h",
                 $time, reset, req, grant, err, wr_en, wr_addr, wr_data);
    endtask

    task automatic set_addrs(input logic [3:0] a0, a1, a2, a3);
        req_addr = {a3, a2, a1, a0};
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        reset = 1'b1;
        req   = 4'hF;
        set_addrs(4'h1, 4'h2, 4'h3, 4'h4);
        req_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        // Reset with all requests active.
        step();
        step();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_addr",  32'(wr_addr), 32'd0);
        check("rst_data",  wr_data, 32'd0);

        // Round robin with all four requesters held.
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            check("rr_grant", 32'(grant), 32'(rr_exp[n]));
        end
        req = 4'b0000;
        step();

        // Single request.
        req = 4'b0100;
        set_addrs(4'h0, 4'h0, 4'h5, 4'h0);
        req_data[WIDTH*2 +: WIDTH] = 32'hDEADBEEF;
        step();
        check("single_data",  wr_data, 32'hDEADBEEF);
        check("single_addr",  32'(wr_addr), 32'h5);
        check("single_grant", 32'(grant), 32'b0100);
        req = 4'b0000;
        step();
        check("single_after", 32'(wr_en), 32'd0);

        // A request held by requester 0 wins every other cycle.
        req = 4'b0001;
        for (int n = 0; n < 6; n++) begin
            step();
            check("held_wr_en", 32'(wr_en), (n % 2 == 0) ? 32'd1 : 32'd0);
        end
        req = 4'b0000;
        step();

        // R15 protection.
        req = 4'b0010;
        set_addrs(4'h0, 4'hF, 4'h0, 4'h0);
        step();
        check("r15_err",   32'(err),   32'b0010);
        check("r15_wr_en", 32'(wr_en), 32'd0);
        req = 4'b0001;
        set_addrs(4'hF, 4'h0, 4'h0, 4'h0);
        step();
        check("r15_req0_addr", 32'(wr_addr), 32'hF);
        check("r15_req0_err",  32'(err), 32'd0);
        req = 4'b0000;
        step();

        // Reset in the middle of a stream of requests.
        req = 4'hF;
        set_addrs(4'h1, 4'h2, 4'h3, 4'h4);
        step(); step(); step();
        reset = 1'b1;
        step();
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        reset = 1'b0;
        step();
        check("midrst_restart", 32'(grant), 32'b0001);

        // Randomized traffic, with R15 destinations and occasional resets.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            req   = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                req_addr[4*i +: 4]          = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                req_data[WIDTH*i +: WIDTH]  = $urandom;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port among four requesters (e.g. ALU writeback, load unit, link/branch unit, debug port) using round-robin arbitration. Each cycle it selects at most one request and registers the write. It drives the 4-bit register index into the register file's 4-to-16 write-enable decoder, along with the write enable and write data. It optionally blocks writes to R15 (PC) from every requester except requester 0.

Parameters:
WIDTH, 32, data width of a register write
PROTECT_R15, 1, when 1 only requester 0 may write register index 4'hF

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  4  req[i] high = requester i wants a write this cycle (level)
req_addr  input  16  requester i destination index at bits [4i+3:4i]
req_data  input  4*WIDTH  requester i data at bits [WIDTH*(i+1)-1:WIDTH*i]
grant  output  4  registered one-hot; grant[i]=1 for the cycle after requester i's write was accepted
err  output  4  registered; err[i]=1 for the cycle after requester i presented an illegal R15 write
wr_en  output  1  registered write enable to register file
wr_addr  output  4  registered index to the 4-to-16 write decoder
wr_data  output  WIDTH  registered write data

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset (sampled high at an edge):
  - grant=0, err=0, wr_en=0, wr_addr=0, wr_data=0.
  - Round-robin pointer last=3, so requester 0 has first priority after reset.
  - Reset overrides every request presented in the same cycle; a write in flight is dropped, and wr_en is low in the cycle after the reset edge.
- Illegal request: illegal[i] = PROTECT_R15 && i!=0 && req[i] && req_addr[i]==4'hF. Illegal requests never win arbitration.
- Masking: mask[i] = grant[i], so a requester granted in this cycle is not eligible in the same cycle.
- Eligibility: elig[i] = req[i] && !illegal[i] && !mask[i].
- Arbitration is combinational. Winner = first eligible index scanning last+1, last+2, last+3, last (mod 4).
- At each edge, when not in reset:
  - If any elig bit is set: wr_en<=1, wr_addr<=req_addr[winner], wr_data<=req_data[winner], grant<=onehot(winner), last<=winner.
  - If no elig bit is set: wr_en<=0, grant<=0, last unchanged. wr_addr and wr_data hold their previous values (don't-care while wr_en=0).
  - err[i] <= illegal[i], independent of arbitration. It stays asserted on every cycle following one where the illegal request is still held.
- Latency: request sampled at edge E; register file write and grant both occur in the cycle after E. The register file commits at edge E+1.
- Handshake: a requester must drop or change req/req_addr/req_data during its grant cycle. A request still held then is masked and is treated as a new request from the following cycle. A continuously held request therefore wins at most every other cycle.
- Throughput: one write per cycle when two or more requesters alternate.
- Fairness: any eligible requester waits at most 3 grants to other requesters before winning.
- With PROTECT_R15=0, index 15 is an ordinary destination and err is constantly 0.
- At most one bit of grant is set; grant!=0 implies wr_en=1.

Test Plan:
- Reset then idle: assert reset 2 cycles with req=4'hF -> all outputs 0 during and after reset; first accepted write after reset is requester 0.
- Single request: req=4'b0100, addr2=4'h5, data2=32'hDEADBEEF for one cycle -> next cycle wr_en=1, wr_addr=5, wr_data=DEADBEEF, grant=4'b0100; following cycle wr_en=0.
- Round-robin: req=4'hF held, distinct addrs 1,2,3,4 -> grant sequence 0001,0010,0100,1000,0001; no requester granted twice in a row.
- Held single requester: req=4'b0001 held 6 cycles -> wr_en pattern 1,0,1,0,1,0 (mask rule).
- R15 protection: req=4'b0010 with addr1=4'hF -> err=4'b0010 next cycle, wr_en=0, grant=0. Same stimulus on requester 0 -> write accepted with wr_addr=15, err=0.
- Reset mid-stream: req=4'hF running, assert reset for one cycle -> next cycle wr_en=0, grant=0; arbitration restarts at requester 0.
